// File: rtl/reaction_timer_master_if.sv
// Avalon-MM bus between the reaction timer master and the interval timer slave.
// No waitrequest: every write completes in the cycle it is presented, and
// readdata is registered by the slave, valid the cycle after the read address.
interface reaction_timer_master_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/reaction_timer_master.sv
// Reaction timer master: arms the interval timer on start, services each 1 ms
// timer IRQ with a status read-check-clear sequence that counts one tick, and
// disarms the timer on stop, freezing elapsed_ms.
//
// Handshake: there is no valid/ready pair. start and stop are single-cycle
// requests sampled on the rising clock edge. A bus cycle is live whenever
// chipselect is 1 (write_n selects write/read) and always completes in that
// cycle. done is a one-cycle pulse on the cycle after the disarm write.
//
// START_VALUE is the value elapsed_ms takes when a start is accepted; it is 0
// in the product and only differs when exercising the saturation boundary.
module reaction_timer_master #(
    parameter logic [15:0] START_VALUE = 16'h0000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            timer_irq,
    reaction_timer_master_if.master         avm,
    output logic [15:0]                     elapsed_ms,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [3:0]                      fsm_state
);

    localparam logic [2:0] STATUS_ADDR = 3'd0;
    localparam logic [2:0] CTRL_ADDR   = 3'd1;
    localparam logic [2:0] PERIOD_ADDR = 3'd2;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_PERIOD = 4'd1,
        W_STAT   = 4'd2,
        W_CTRL   = 4'd3,
        RUN      = 4'd4,
        RD       = 4'd5,
        CHK      = 4'd6,
        CLR      = 4'd7,
        DISARM   = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t state;
    state_t next_state;

    logic        stop_pending;

    // Registered bus and status outputs plus their next-cycle values.
    logic [2:0]  address_q;
    logic        chipselect_q;
    logic        write_n_q;
    logic [15:0] writedata_q;
    logic        busy_q;
    logic        done_q;

    logic [2:0]  address_d;
    logic        chipselect_d;
    logic        write_n_d;
    logic [15:0] writedata_d;
    logic        busy_d;
    logic        done_d;

    // Only the timeout flag of the status register matters here.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avm.readdata[15:1]};

    // A stop arriving while a sequence is in flight is remembered here.
    logic in_sequence;
    assign in_sequence = (state == W_PERIOD) || (state == W_STAT) ||
                         (state == W_CTRL)   || (state == RUN)    ||
                         (state == RD)       || (state == CHK)    ||
                         (state == CLR);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; IRQ service wins over stop in RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = W_PERIOD;
            W_PERIOD: next_state = W_STAT;
            W_STAT:   next_state = W_CTRL;
            W_CTRL:   next_state = RUN;
            RUN: begin
                if (timer_irq) begin
                    next_state = RD;
                end else if (stop || stop_pending) begin
                    next_state = DISARM;
                end
            end
            RD:       next_state = CHK;
            CHK: begin
                if (avm.readdata[0]) begin
                    next_state = CLR;
                end else if (stop_pending) begin
                    next_state = DISARM;
                end else begin
                    next_state = RUN;
                end
            end
            CLR:      next_state = stop_pending ? DISARM : RUN;
            DISARM:   next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode from the next state so the registered bus lines up with the state.
    always_comb begin
        address_d    = 3'd0;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = 16'h0000;
        done_d       = 1'b0;
        busy_d       = (next_state != IDLE) && (next_state != DONE);
        case (next_state)
            W_PERIOD: begin
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                address_d    = PERIOD_ADDR;
            end
            W_STAT, CLR: begin
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                address_d    = STATUS_ADDR;
            end
            W_CTRL: begin
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                address_d    = CTRL_ADDR;
                writedata_d  = 16'h0001;
            end
            RD: begin
                chipselect_d = 1'b1;
                address_d    = STATUS_ADDR;
            end
            DISARM: begin
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                address_d    = CTRL_ADDR;
            end
            DONE:     done_d = 1'b1;
            default:  ;
        endcase
    end

    // Output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= 3'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            address_q    <= address_d;
            chipselect_q <= chipselect_d;
            write_n_q    <= write_n_d;
            writedata_q  <= writedata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Tick counter, saturation flag and pending-stop memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elapsed_ms   <= 16'h0000;
            overflow     <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                elapsed_ms   <= START_VALUE;
                overflow     <= 1'b0;
                stop_pending <= 1'b0;
            end else begin
                if (in_sequence && stop) begin
                    stop_pending <= 1'b1;
                end
                if (state == CLR) begin
                    if (elapsed_ms == 16'hFFFF) begin
                        overflow <= 1'b1;
                    end else begin
                        elapsed_ms <= elapsed_ms + 16'd1;
                    end
                end
            end
        end
    end

    assign avm.address    = address_q;
    assign avm.chipselect = chipselect_q;
    assign avm.write_n    = write_n_q;
    assign avm.writedata  = writedata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fsm_state      = state;

endmodule

// File: tb/tb_reaction_timer_master.sv
// Bench for reaction_timer_master: a timer-slave model answers status reads,
// every bus write is checked in order against an expected queue, and a second
// instance preset near the limit exercises saturation.
module tb_reaction_timer_master;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_W_CTRL = 4'd3;
    localparam logic [3:0] S_RUN    = 4'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, stop, timer_irq;
    logic [15:0] elapsed_ms;
    logic        busy, done, overflow;
    logic [3:0]  fsm_a;

    logic        start_b, stop_b, irq_b;
    logic [15:0] elapsed_b;
    logic        busy_b, done_b, overflow_b;
    logic [3:0]  fsm_b;

    reaction_timer_master_if bus_a();
    reaction_timer_master_if bus_b();

    reaction_timer_master dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .timer_irq(timer_irq), .avm(bus_a), .elapsed_ms(elapsed_ms),
        .busy(busy), .done(done), .overflow(overflow), .fsm_state(fsm_a)
    );

    reaction_timer_master #(.START_VALUE(16'hFFFE)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b),
        .timer_irq(irq_b), .avm(bus_b), .elapsed_ms(elapsed_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .fsm_state(fsm_b)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cs_cnt   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timer slave model: IRQ with a real timeout sets the flag, a status write
    // clears it, a status read returns it registered.
    logic flag;
    logic irq_good;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag          <= 1'b0;
            bus_a.readdata <= 16'h0000;
        end else begin
            if (timer_irq && irq_good) begin
                flag <= 1'b1;
            end else if (bus_a.chipselect && !bus_a.write_n && bus_a.address == 3'd0) begin
                flag <= 1'b0;
            end
            if (bus_a.chipselect && bus_a.write_n && bus_a.address == 3'd0) begin
                bus_a.readdata <= {15'd0, flag};
            end
        end
    end

    // Second instance's slave always reports a timeout.
    always @(posedge clk) bus_b.readdata <= 16'h0001;

    // Scoreboard: every write is popped against the expected queue.
    always @(negedge clk) begin
        logic [18:0] e;
        if (bus_a.chipselect === 1'b1) begin
            cs_cnt++;
            if (bus_a.write_n === 1'b0) begin
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr_data", {13'd0, bus_a.address, bus_a.writedata}, {13'd0, e});
                end
            end else begin
                rd_cnt++;
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input bit sel_b, input logic [3:0] target, input string tag);
        int n = 0;
        while (((sel_b ? fsm_b : fsm_a) !== target) && n < 300) begin
            tick();
            n++;
        end
        check({"reach_", tag}, {28'd0, sel_b ? fsm_b : fsm_a}, {28'd0, target});
    endtask

    task automatic do_start();
        exp_q.push_back({3'd2, 16'h0000});
        exp_q.push_back({3'd0, 16'h0000});
        exp_q.push_back({3'd1, 16'h0001});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fire_irq(input logic good);
        if (good) exp_q.push_back({3'd0, 16'h0000});
        irq_good  = good;
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        irq_good  = 1'b0;
    endtask

    task automatic do_stop();
        exp_q.push_back({3'd1, 16'h0000});
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic fire_irq_b();
        irq_b = 1'b1;
        tick();
        irq_b = 1'b0;
    endtask

    initial begin
        int cs0, rd0, done0;
        bit saw_run;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; timer_irq = 1'b0; irq_good = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; irq_b = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state and ten quiet cycles.
        cs0 = cs_cnt;
        repeat (10) tick();
        check("idle_no_cs", cs_cnt - cs0, 0);
        check("rst_write_n", {31'd0, bus_a.write_n}, 1);
        check("rst_address", {29'd0, bus_a.address}, 0);
        check("rst_writedata", {16'd0, bus_a.writedata}, 0);
        check("rst_elapsed", {16'd0, elapsed_ms}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);

        // Three serviced IRQs then stop; a stray start in RUN must do nothing.
        rd0 = rd_cnt; done0 = done_cnt;
        do_start();
        check("busy_rises", {31'd0, busy}, 1);
        wait_state(0, S_RUN, "run1");
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_state(0, S_RUN, "run_irq");
            fire_irq(1'b1);
        end
        wait_state(0, S_RUN, "run2");
        check("elapsed_3_pre", {16'd0, elapsed_ms}, 3);
        do_stop();
        wait_state(0, S_IDLE, "idle1");
        check("elapsed_3", {16'd0, elapsed_ms}, 3);
        check("reads_3", rd_cnt - rd0, 3);
        check("done_once", done_cnt - done0, 1);
        check("busy_low", {31'd0, busy}, 0);
        check("no_overflow", {31'd0, overflow}, 0);

        // Spurious IRQ, then stop during the RD cycle.
        rd0 = rd_cnt; done0 = done_cnt;
        do_start();
        check("elapsed_cleared", {16'd0, elapsed_ms}, 0);
        wait_state(0, S_RUN, "run3");
        fire_irq(1'b1);
        wait_state(0, S_RUN, "run4");
        check("elapsed_1", {16'd0, elapsed_ms}, 1);
        fire_irq(1'b0);
        wait_state(0, S_RUN, "run_spur");
        check("spurious_no_count", {16'd0, elapsed_ms}, 1);
        check("spurious_read", rd_cnt - rd0, 2);
        fire_irq(1'b1);
        do_stop();
        saw_run = 1'b0;
        for (int n = 0; n < 20 && fsm_a !== S_IDLE; n++) begin
            if (fsm_a === S_RUN) saw_run = 1'b1;
            tick();
        end
        check("stop_rd_idle", {28'd0, fsm_a}, {28'd0, S_IDLE});
        check("stop_rd_no_run", {31'd0, saw_run}, 0);
        check("elapsed_2", {16'd0, elapsed_ms}, 2);
        check("done_once2", done_cnt - done0, 1);
        repeat (5) tick();
        check("elapsed_hold", {16'd0, elapsed_ms}, 2);

        // Asynchronous reset in W_CTRL, then a full re-arm.
        do_start();
        wait_state(0, S_W_CTRL, "wctrl");
        reset_n = 1'b0;
        #1;
        check("arst_cs", {31'd0, bus_a.chipselect}, 0);
        check("arst_write_n", {31'd0, bus_a.write_n}, 1);
        check("arst_address", {29'd0, bus_a.address}, 0);
        check("arst_writedata", {16'd0, bus_a.writedata}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_elapsed", {16'd0, elapsed_ms}, 0);
        check("arst_state", {28'd0, fsm_a}, {28'd0, S_IDLE});
        tick();
        reset_n = 1'b1;
        tick();
        do_start();
        wait_state(0, S_RUN, "run5");
        fire_irq(1'b1);
        wait_state(0, S_RUN, "run6");
        do_stop();
        wait_state(0, S_IDLE, "idle3");
        check("rearm_elapsed", {16'd0, elapsed_ms}, 1);

        // Saturation on the preset instance.
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_state(1, S_RUN, "b_run");
        check("b_preset", {16'd0, elapsed_b}, 32'hFFFE);
        fire_irq_b();
        wait_state(1, S_RUN, "b_run2");
        check("b_elapsed_max", {16'd0, elapsed_b}, 32'hFFFF);
        fire_irq_b();
        wait_state(1, S_RUN, "b_run3");
        check("b_saturated", {16'd0, elapsed_b}, 32'hFFFF);
        check("b_overflow", {31'd0, overflow_b}, 1);

        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
